// File: rtl/fall_timer_if.sv
// Handshake bundle between the gravity timer and the game logic.
// Inputs flow master -> slave; tick/state/period flow back.
interface fall_timer_if #(
    parameter int CNT_W   = 34,
    parameter int LEVEL_W = 4
);
    logic               en;
    logic               pause;
    logic               restart;
    logic [LEVEL_W-1:0] level;
    logic               soft_drop;
    logic               tick;
    logic [1:0]         state_o;
    logic [CNT_W-1:0]   period_o;

    modport master (
        output en, pause, restart, level, soft_drop,
        input  tick, state_o, period_o
    );

    modport slave (
        input  en, pause, restart, level, soft_drop,
        output tick, state_o, period_o
    );
endinterface

// File: rtl/fall_timer.sv
// Gravity timer: one-cycle drop tick, period falling linearly with level.
// Optional soft-drop speed-up enabled by defining FALL_SOFT_DROP_EN.
module fall_timer #(
    parameter int     CNT_W       = 34,
    parameter int     LEVEL_W     = 4,
    parameter int     NUM_LEVELS  = 10,
    parameter longint BASE_PERIOD = 100_000_000,
    parameter longint STEP        = 9_000_000,
    parameter longint MIN_PERIOD  = 5_000_000,
    parameter int     SOFT_SHIFT  = 3
) (
    input  logic      clk,
    input  logic      rst_1plus,
    fall_timer_if.slave bus
);
    localparam int DW = CNT_W + LEVEL_W;
    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [DW-1:0] BASE_D = DW'(BASE_PERIOD);
    localparam logic [DW-1:0] STEP_D = DW'(STEP);
    localparam logic [DW-1:0] SPAN_D = DW'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [LEVEL_W-1:0] lvl_s;
    logic [DW-1:0]      dec;
    logic [CNT_W-1:0]   period, period_eff;
    logic               hit, tick;

    always_comb begin
        lvl_s  = (bus.level > LVL_MAX) ? LVL_MAX : bus.level;
        dec    = DW'(lvl_s) * STEP_D;
        period = (dec >= SPAN_D) ? MIN_C : CNT_W'(BASE_D - dec);
    end

`ifdef FALL_SOFT_DROP_EN
    logic [CNT_W-1:0] shifted;
    always_comb begin
        shifted    = period >> SOFT_SHIFT;
        period_eff = period;
        if (bus.soft_drop)
            period_eff = (shifted == '0) ? ONE_C : shifted;
    end
`else
    logic unused_soft;
    assign unused_soft = bus.soft_drop;
    assign period_eff  = period;
`endif

    // >= rather than == so a shortened period fires at once instead of wrapping
    assign hit = (cnt >= period_eff - ONE_C);

    always_ff @(posedge clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tick    = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
                RUN: begin
                    if (bus.restart) begin
                        cnt_n = '0;
                    end else if (bus.pause) begin
                        state_n = PAUSED;
                    end else if (hit) begin
                        tick  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + ONE_C;
                    end
                end
                PAUSED: begin
                    if (bus.restart)
                        cnt_n = '0;
                    if (!bus.pause)
                        state_n = RUN;
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign bus.tick     = tick;
    assign bus.state_o  = state;
    assign bus.period_o = period_eff;
endmodule
